// File: rtl/wb_arb.sv
// wb_arb: write-back arbiter merging EX results and FIFO-buffered LSU results into one regfile write port.
// Optional: define WB_BYPASS_EN to let an LSU result skip an empty FIFO when no EX write is selected.
module wb_arb #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int REG_DEPTH    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic [31:0] ex_rd_data_i,
  input  logic        ex_rd_wr_en_i,
  output logic        wb_ex_stall_o,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic [4:0]  lsu_rd_addr_i,
  input  logic [31:0] lsu_rd_data_i,
  input  logic        id_lsu_issue_i,
  input  logic [4:0]  id_lsu_rd_addr_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  output logic        wb_rs1_busy_o,
  output logic        wb_rs2_busy_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic [31:0] wb_rd_data_o,
  output logic        wb_rd_wr_en_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]           fifo_addr_q [FIFO_DEPTH];
  logic [31:0]          fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]          count_q, count_d;
  logic [SW-1:0]        starve_q, starve_d;
  logic [REG_DEPTH-1:0] pending_q, pending_d;
  logic [4:0]           out_addr_q, out_addr_d;
  logic [31:0]          out_data_q, out_data_d;
  logic                 out_we_q, out_we_d;

  logic fifo_empty, fifo_full, lsu_acc, force_drain, ex_sel, pop, push, bypass;
  logic [4:0]  head_addr;
  logic [31:0] head_data;

  // LSU handshake: a result transfers on a cycle where lsu_valid_i && lsu_ready_o at
  // the rising edge; ready depends only on FIFO occupancy, never on valid.
  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == (PW+1)'(FIFO_DEPTH));
  assign lsu_ready_o = !rst && !fifo_full;
  assign lsu_acc     = lsu_valid_i && lsu_ready_o;

  assign force_drain   = !fifo_empty && (starve_q == SW'(STARVE_LIMIT));
  assign ex_sel        = !force_drain && ex_rd_wr_en_i && (ex_rd_addr_i != '0);
  assign pop           = force_drain || (!ex_sel && !fifo_empty);
  assign wb_ex_stall_o = !rst && force_drain && ex_rd_wr_en_i && (ex_rd_addr_i != '0);

`ifdef WB_BYPASS_EN
  assign bypass = fifo_empty && !ex_sel && lsu_acc && (lsu_rd_addr_i != '0);
`else
  assign bypass = 1'b0;
`endif
  assign push = lsu_acc && (lsu_rd_addr_i != '0) && !bypass;

  assign head_addr = fifo_addr_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  assign wb_rs1_busy_o = (id_rs1_addr_i != '0) && pending_q[id_rs1_addr_i];
  assign wb_rs2_busy_o = (id_rs2_addr_i != '0) && pending_q[id_rs2_addr_i];

  assign wb_rd_addr_o  = out_addr_q;
  assign wb_rd_data_o  = out_data_q;
  assign wb_rd_wr_en_o = out_we_q;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    starve_d   = starve_q;
    pending_d  = pending_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    out_we_d   = 1'b0;
    if (pop) begin
      out_addr_d           = head_addr;
      out_data_d           = head_data;
      out_we_d             = 1'b1;
      rd_ptr_d             = rd_ptr_q + PW'(1);
      pending_d[head_addr] = 1'b0;
    end else if (ex_sel) begin
      out_addr_d = ex_rd_addr_i;
      out_data_d = ex_rd_data_i;
      out_we_d   = 1'b1;
    end else if (bypass) begin
      out_addr_d               = lsu_rd_addr_i;
      out_data_d               = lsu_rd_data_i;
      out_we_d                 = 1'b1;
      pending_d[lsu_rd_addr_i] = 1'b0;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (ex_sel && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_d = starve_q + SW'(1);
    end
    // A new issue to the same register outranks the retirement of an older result.
    if (id_lsu_issue_i && (id_lsu_rd_addr_i != '0)) begin
      pending_d[id_lsu_rd_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      pending_q  <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      out_we_q   <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      pending_q  <= pending_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      out_we_q   <= out_we_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= lsu_rd_addr_i;
      fifo_data_q[wr_ptr_q] <= lsu_rd_data_i;
    end
  end
endmodule

// File: tb/tb_wb_arb.sv
// Directed testbench for wb_arb; define WB_BYPASS_EN to check the bypass build.
module tb_wb_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_rd_addr_i;
  logic [31:0] ex_rd_data_i;
  logic        ex_rd_wr_en_i;
  logic        wb_ex_stall_o;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_rd_addr_i;
  logic [31:0] lsu_rd_data_i;
  logic        id_lsu_issue_i;
  logic [4:0]  id_lsu_rd_addr_i;
  logic [4:0]  id_rs1_addr_i;
  logic [4:0]  id_rs2_addr_i;
  logic        wb_rs1_busy_o;
  logic        wb_rs2_busy_o;
  logic [4:0]  wb_rd_addr_o;
  logic [31:0] wb_rd_data_o;
  logic        wb_rd_wr_en_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] tb_pend = '0;

  always #5 clk = ~clk;

  wb_arb dut (
    .clk(clk), .rst(rst),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_data_i(ex_rd_data_i), .ex_rd_wr_en_i(ex_rd_wr_en_i),
    .wb_ex_stall_o(wb_ex_stall_o),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_rd_addr_i(lsu_rd_addr_i), .lsu_rd_data_i(lsu_rd_data_i),
    .id_lsu_issue_i(id_lsu_issue_i), .id_lsu_rd_addr_i(id_lsu_rd_addr_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .wb_rs1_busy_o(wb_rs1_busy_o), .wb_rs2_busy_o(wb_rs2_busy_o),
    .wb_rd_addr_o(wb_rd_addr_o), .wb_rd_data_o(wb_rd_data_o), .wb_rd_wr_en_o(wb_rd_wr_en_o)
  );

  // ID must never let EX write a register with an outstanding long-latency result.
  always @(posedge clk) begin
    if (!rst && ex_rd_wr_en_i && (ex_rd_addr_i != 5'd0) && tb_pend[ex_rd_addr_i])
      $error("illegal EX write to pending register x%0d", ex_rd_addr_i);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_rd_addr_i = '0; ex_rd_data_i = '0; ex_rd_wr_en_i = 1'b0;
    lsu_valid_i = 1'b0; lsu_rd_addr_i = '0; lsu_rd_data_i = '0;
    id_lsu_issue_i = 1'b0; id_lsu_rd_addr_i = '0;
    id_rs1_addr_i = '0; id_rs2_addr_i = '0;
  endtask

  task automatic test_reset();
    idle();
    ex_rd_wr_en_i = 1'b1; ex_rd_addr_i = 5'd10; ex_rd_data_i = 32'hAAAA;
    lsu_valid_i = 1'b1; lsu_rd_addr_i = 5'd3; lsu_rd_data_i = 32'h33;
    id_lsu_issue_i = 1'b1; id_lsu_rd_addr_i = 5'd7; tb_pend[7] = 1'b1;
    step();
    id_lsu_issue_i = 1'b0; lsu_rd_addr_i = 5'd4; lsu_rd_data_i = 32'h44;
    step();
    rst = 1'b1; id_rs1_addr_i = 5'd7; id_rs2_addr_i = 5'd3;
    #1;
    n_tests++; if (lsu_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b exp 0", lsu_ready_o); end
    n_tests++; if (wb_ex_stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b exp 0", wb_ex_stall_o); end
    for (int i = 0; i < 2; i++) begin
      step();
      tb_pend = '0;
      n_tests++;
      if (wb_rd_wr_en_o !== 1'b0 || wb_rd_addr_o !== 5'd0 || wb_rd_data_o !== 32'd0) begin
        n_fail++;
        $display("FAIL rst_outputs: got we=%b addr=%0d data=%h exp we=0 addr=0 data=0", wb_rd_wr_en_o, wb_rd_addr_o, wb_rd_data_o);
      end
      n_tests++; if (lsu_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready_hold: got %b exp 0", lsu_ready_o); end
      n_tests++; if (wb_rs1_busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", wb_rs1_busy_o); end
    end
    idle(); rst = 1'b0; id_rs1_addr_i = 5'd7; id_rs2_addr_i = 5'd3;
    #1;
    n_tests++; if (lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b exp 1", lsu_ready_o); end
    n_tests++; if (wb_rs1_busy_o !== 1'b0 || wb_rs2_busy_o !== 1'b0) begin n_fail++; $display("FAIL post_rst_busy: got %b%b exp 00", wb_rs1_busy_o, wb_rs2_busy_o); end
    step();
    n_tests++; if (wb_rd_wr_en_o !== 1'b0) begin n_fail++; $display("FAIL post_rst_no_write: got %b exp 0", wb_rd_wr_en_o); end
  endtask

  task automatic test_ex_write();
    idle();
    ex_rd_wr_en_i = 1'b1; ex_rd_addr_i = 5'd5; ex_rd_data_i = 32'h1234;
    #1;
    n_tests++; if (wb_ex_stall_o !== 1'b0) begin n_fail++; $display("FAIL ex_stall: got %b exp 0", wb_ex_stall_o); end
    step();
    ex_rd_addr_i = 5'd0; ex_rd_data_i = 32'hFFFF;
    n_tests++;
    if (wb_rd_wr_en_o !== 1'b1 || wb_rd_addr_o !== 5'd5 || wb_rd_data_o !== 32'h1234) begin
      n_fail++;
      $display("FAIL ex_write: got we=%b addr=%0d data=%h exp we=1 addr=5 data=1234", wb_rd_wr_en_o, wb_rd_addr_o, wb_rd_data_o);
    end
    #1;
    n_tests++; if (wb_ex_stall_o !== 1'b0) begin n_fail++; $display("FAIL ex_x0_stall: got %b exp 0", wb_ex_stall_o); end
    step();
    ex_rd_wr_en_i = 1'b0;
    n_tests++;
    if (wb_rd_wr_en_o !== 1'b0 || wb_rd_addr_o !== 5'd5 || wb_rd_data_o !== 32'h1234) begin
      n_fail++;
      $display("FAIL ex_x0_write: got we=%b addr=%0d data=%h exp we=0 addr=5 data=1234", wb_rd_wr_en_o, wb_rd_addr_o, wb_rd_data_o);
    end
  endtask

  task automatic test_lsu_latency();
    idle();
    id_lsu_issue_i = 1'b1; id_lsu_rd_addr_i = 5'd7; tb_pend[7] = 1'b1;
    step();
    id_lsu_issue_i = 1'b0; id_rs1_addr_i = 5'd7;
    lsu_valid_i = 1'b1; lsu_rd_addr_i = 5'd7; lsu_rd_data_i = 32'hDEAD;
    #1;
    n_tests++; if (wb_rs1_busy_o !== 1'b1) begin n_fail++; $display("FAIL lat_busy_set: got %b exp 1", wb_rs1_busy_o); end
    n_tests++; if (lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL lat_ready: got %b exp 1", lsu_ready_o); end
    step();
    lsu_valid_i = 1'b0;
`ifndef WB_BYPASS_EN
    n_tests++; if (wb_rd_wr_en_o !== 1'b0) begin n_fail++; $display("FAIL lat_early: got %b exp 0", wb_rd_wr_en_o); end
    n_tests++; if (wb_rs1_busy_o !== 1'b1) begin n_fail++; $display("FAIL lat_busy_hold: got %b exp 1", wb_rs1_busy_o); end
    step();
`endif
    n_tests++;
    if (wb_rd_wr_en_o !== 1'b1 || wb_rd_addr_o !== 5'd7 || wb_rd_data_o !== 32'hDEAD) begin
      n_fail++;
      $display("FAIL lat_write: got we=%b addr=%0d data=%h exp we=1 addr=7 data=dead", wb_rd_wr_en_o, wb_rd_addr_o, wb_rd_data_o);
    end
    n_tests++; if (wb_rs1_busy_o !== 1'b0) begin n_fail++; $display("FAIL lat_busy_clr: got %b exp 0", wb_rs1_busy_o); end
    tb_pend[7] = 1'b0;
    step();
    n_tests++; if (wb_rd_wr_en_o !== 1'b0) begin n_fail++; $display("FAIL lat_single: got %b exp 0", wb_rd_wr_en_o); end
  endtask

  task automatic test_starve();
    idle();
    ex_rd_wr_en_i = 1'b1; ex_rd_addr_i = 5'd20;
    for (int c = 0; c < 9; c++) begin
      ex_rd_data_i = 32'hE000 + c;
      if (c < 4) begin
        lsu_valid_i = 1'b1; lsu_rd_addr_i = 5'(c + 1); lsu_rd_data_i = 32'h100 + c + 1;
      end else begin
        lsu_valid_i = 1'b0;
      end
      #1;
      n_tests++; if (wb_ex_stall_o !== 1'b0) begin n_fail++; $display("FAIL starve_early_stall c%0d: got %b exp 0", c, wb_ex_stall_o); end
      if (c == 4) begin
        n_tests++; if (lsu_ready_o !== 1'b0) begin n_fail++; $display("FAIL starve_full_ready: got %b exp 0", lsu_ready_o); end
      end
      step();
      n_tests++;
      if (wb_rd_wr_en_o !== 1'b1 || wb_rd_addr_o !== 5'd20 || wb_rd_data_o !== 32'hE000 + c) begin
        n_fail++;
        $display("FAIL starve_ex_win c%0d: got we=%b addr=%0d data=%h exp we=1 addr=20 data=%h", c, wb_rd_wr_en_o, wb_rd_addr_o, wb_rd_data_o, 32'hE000 + c);
      end
    end
    ex_rd_data_i = 32'hE009;
    #1;
    n_tests++; if (wb_ex_stall_o !== 1'b1) begin n_fail++; $display("FAIL starve_force_stall: got %b exp 1", wb_ex_stall_o); end
    n_tests++; if (lsu_ready_o !== 1'b0) begin n_fail++; $display("FAIL starve_pop_full_ready: got %b exp 0", lsu_ready_o); end
    step();
    n_tests++;
    if (wb_rd_wr_en_o !== 1'b1 || wb_rd_addr_o !== 5'd1 || wb_rd_data_o !== 32'h101) begin
      n_fail++;
      $display("FAIL starve_force_pop: got we=%b addr=%0d data=%h exp we=1 addr=1 data=101", wb_rd_wr_en_o, wb_rd_addr_o, wb_rd_data_o);
    end
    #1;
    n_tests++; if (wb_ex_stall_o !== 1'b0) begin n_fail++; $display("FAIL starve_after_stall: got %b exp 0", wb_ex_stall_o); end
    n_tests++; if (lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL starve_after_ready: got %b exp 1", lsu_ready_o); end
    step();
    ex_rd_wr_en_i = 1'b0;
    n_tests++;
    if (wb_rd_wr_en_o !== 1'b1 || wb_rd_addr_o !== 5'd20 || wb_rd_data_o !== 32'hE009) begin
      n_fail++;
      $display("FAIL starve_held_ex: got we=%b addr=%0d data=%h exp we=1 addr=20 data=e009", wb_rd_wr_en_o, wb_rd_addr_o, wb_rd_data_o);
    end
    for (int k = 2; k <= 4; k++) begin
      step();
      n_tests++;
      if (wb_rd_wr_en_o !== 1'b1 || wb_rd_addr_o !== 5'(k) || wb_rd_data_o !== 32'h100 + k) begin
        n_fail++;
        $display("FAIL starve_drain x%0d: got we=%b addr=%0d data=%h exp we=1 addr=%0d data=%h", k, wb_rd_wr_en_o, wb_rd_addr_o, wb_rd_data_o, k, 32'h100 + k);
      end
    end
    step();
    n_tests++; if (wb_rd_wr_en_o !== 1'b0) begin n_fail++; $display("FAIL starve_empty: got %b exp 0", wb_rd_wr_en_o); end
  endtask

  task automatic test_set_wins();
    idle();
    id_lsu_issue_i = 1'b1; id_lsu_rd_addr_i = 5'd9; tb_pend[9] = 1'b1;
    step();
    id_lsu_issue_i = 1'b0; id_rs1_addr_i = 5'd9;
    lsu_valid_i = 1'b1; lsu_rd_addr_i = 5'd9; lsu_rd_data_i = 32'h0909;
`ifdef WB_BYPASS_EN
    id_lsu_issue_i = 1'b1;
    step();
`else
    step();
    lsu_valid_i = 1'b0; id_lsu_issue_i = 1'b1;
    step();
`endif
    lsu_valid_i = 1'b0; id_lsu_issue_i = 1'b0;
    n_tests++;
    if (wb_rd_wr_en_o !== 1'b1 || wb_rd_addr_o !== 5'd9 || wb_rd_data_o !== 32'h0909) begin
      n_fail++;
      $display("FAIL setwin_write: got we=%b addr=%0d data=%h exp we=1 addr=9 data=909", wb_rd_wr_en_o, wb_rd_addr_o, wb_rd_data_o);
    end
    n_tests++; if (wb_rs1_busy_o !== 1'b1) begin n_fail++; $display("FAIL setwin_busy: got %b exp 1", wb_rs1_busy_o); end
    lsu_valid_i = 1'b1; lsu_rd_addr_i = 5'd9; lsu_rd_data_i = 32'h9999;
    step();
    lsu_valid_i = 1'b0;
    step();
    n_tests++; if (wb_rs1_busy_o !== 1'b0) begin n_fail++; $display("FAIL setwin_retire: got %b exp 0", wb_rs1_busy_o); end
    tb_pend[9] = 1'b0;
  endtask

  task automatic test_lsu_x0();
    idle();
    ex_rd_wr_en_i = 1'b1; ex_rd_addr_i = 5'd21; ex_rd_data_i = 32'h2121;
    lsu_valid_i = 1'b1; lsu_rd_addr_i = 5'd0; lsu_rd_data_i = 32'hBAD;
    #1;
    n_tests++; if (lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL x0_ready: got %b exp 1", lsu_ready_o); end
    for (int k = 11; k <= 13; k++) begin
      step();
      lsu_rd_addr_i = 5'(k); lsu_rd_data_i = 32'hA00 + k;
    end
    step();
    lsu_valid_i = 1'b0;
    #1;
    n_tests++; if (lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL x0_not_enqueued: got ready %b exp 1", lsu_ready_o); end
    ex_rd_wr_en_i = 1'b0;
    for (int k = 11; k <= 13; k++) begin
      step();
      n_tests++;
      if (wb_rd_wr_en_o !== 1'b1 || wb_rd_addr_o !== 5'(k) || wb_rd_data_o !== 32'hA00 + k) begin
        n_fail++;
        $display("FAIL x0_drain x%0d: got we=%b addr=%0d data=%h exp we=1 addr=%0d data=%h", k, wb_rd_wr_en_o, wb_rd_addr_o, wb_rd_data_o, k, 32'hA00 + k);
      end
    end
    step();
    n_tests++; if (wb_rd_wr_en_o !== 1'b0) begin n_fail++; $display("FAIL x0_no_write: got %b exp 0", wb_rd_wr_en_o); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    test_reset();
    test_ex_write();
    test_lsu_latency();
    test_starve();
    test_set_wins();
    test_lsu_x0();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
